// File: rtl/multihot_enc_pkg.sv
// Shared types and width helpers for the multi-hot serial encoder.
package multihot_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Index width for an N-bit request vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multihot_serial_encoder_lsb_index_find.sv
// Combinational lowest-set-bit finder: binary index of the lowest set bit,
// whether any bit is set, and whether exactly one bit is set.
module lsb_index_find #(
  parameter int N = 8,
  parameter int W = multihot_enc_pkg::idx_width(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found,
  output logic         single
);

  // Scan high to low so the lowest set bit is the last one written; clearing
  // the lowest bit (vec & (vec-1)) leaves zero only when one bit was set.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
    single = found && ((vec & (vec - N'(1))) == '0);
  end

endmodule

// File: rtl/multihot_serial_encoder.sv
// Multi-hot request vector to serial index stream, lowest bit first, one
// index per out_valid/out_ready handshake. All-zero vectors are flagged on
// zero_err instead of being encoded.
// Optional: define MULTIHOT_ENC_BACK2BACK_EN to accept the next vector on the
// final-beat handshake edge for bubble-free streaming.
module multihot_serial_encoder
  import multihot_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         zero_err
);

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           zero_err_q, zero_err_d;
  logic           found;
  logic           accept, deliver;

  // Outputs decode only registered pending, so idx/last stay stable across
  // stalls; pending is zero in IDLE, which yields idx=0 and last=0.
  lsb_index_find #(.N(N), .W(W)) u_find (
    .vec    (pending_q),
    .idx    (out_idx),
    .found  (found),
    .single (out_last)
  );

  assign out_valid = (state_q == BUSY);
  assign zero_err  = zero_err_q;
  assign deliver   = out_valid && out_ready;

`ifdef MULTIHOT_ENC_BACK2BACK_EN
  assign in_ready = (state_q == IDLE) || ((state_q == BUSY) && out_last && out_ready);
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign accept = in_valid && in_ready;

  // Next state: retire the delivered bit first, then a capture (which can
  // only coincide with the final beat) overrides pending and state.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    zero_err_d = 1'b0;
    if (deliver) begin
      pending_d = pending_q & ~({{(N-1){1'b0}}, 1'b1} << out_idx);
      if (out_last) state_d = IDLE;
    end
    if (accept) begin
      if (in_vec != '0) begin
        pending_d = in_vec;
        state_d   = BUSY;
      end else begin
        zero_err_d = 1'b1;
      end
    end
  end

  // State, pending bits and the zero-vector pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      zero_err_q <= zero_err_d;
    end
  end

  // found is implied by BUSY; kept as a sanity check on the pending invariant.
  logic unused_found;
  assign unused_found = found;

endmodule
